alu_ctrl: RTL and testbench
===========================

ALU_CTRL -- requirements
Module: alu_ctrl

Interface
- REQ-001 SHALL: parameter SIZE, default 31, MSB index of operand/result (data width SIZE+1).
- REQ-002 SHALL: parameter SER_WAIT, default 33, cycles held in WAIT after the serial-add load cycle.
- REQ-003 SHALL: clk  input  1  sole clock, all state updates on posedge.
- REQ-004 SHALL: Rst  input  1  reset, synchronous, active-high.
- REQ-005 SHALL: cmd_valid/cmd_ready  in/out  1/1  command handshake; cmd_op in 4, cmd_a in SIZE+1, cmd_b in SIZE+1, cmd_use_acc in 1.
- REQ-006 SHALL: alu_op out 4, alu_a out SIZE+1, alu_b out SIZE+1, alu_rst out 1  drive the downstream ALU (OP, A, B, Rst); ALU clk shared.
- REQ-007 SHALL: alu_f in SIZE+1, alu_flags in 5 {ZF,CF,OF,SF,PF}  ALU result and flags.
- REQ-008 SHALL: res_valid out 1, res_ready in 1, res_data out SIZE+1, res_flags out 5, res_err out 1, busy out 1  result handshake and status.

Function
- REQ-009 SHALL: states IDLE, EXEC, LOAD, WAIT, DONE; busy = (state != IDLE).
- REQ-010 SHALL: cmd_ready=1 only in IDLE; command accepted on posedge with cmd_valid&cmd_ready; cmd_op/cmd_a/cmd_b registered into alu_op/alu_a/alu_b at that edge and held stable until next acceptance.
- REQ-011 SHALL: IDLE -> EXEC on acceptance when cmd_op in 0000..0111 or 1001..1111; IDLE -> LOAD when cmd_op = 1000.
- REQ-012 SHALL: EXEC lasts one cycle; at its closing edge capture alu_f/alu_flags into res_data/res_flags, go DONE; result valid 2 edges after acceptance.
- REQ-013 SHALL: LOAD lasts one cycle with alu_rst=1; then WAIT with down-counter loaded SER_WAIT, decremented each cycle; capture at edge where counter reads 1, go DONE; result valid SER_WAIT+2 edges after acceptance.
- REQ-014 SHALL: alu_rst=1 during LOAD and whenever Rst=1; 0 otherwise.
- REQ-015 SHALL: res_err=1 with result when cmd_op in 1001..1111 (undefined op); res_data/res_flags then forced to 0.
- REQ-016 SHALL: DONE holds res_valid=1 and res_data/res_flags/res_err stable until res_ready=1; DONE & res_ready -> IDLE, res_valid falls same edge.
- REQ-017 SHALL: cmd_valid ignored outside IDLE; no command queued; res_ready ignored outside DONE.
- REQ-018 SHALL: counter width ceil(log2(SER_WAIT+1)); SER_WAIT < 1 is illegal.

Reset
- REQ-019 SHALL: on posedge with Rst=1: state=IDLE, counter=0, alu_op=0, alu_a=0, alu_b=0, res_data=0, res_flags=0, res_err=0, res_valid=0, busy=0, accumulator=0; cmd_ready=1 from the first cycle after Rst falls.
- REQ-020 SHALL: Rst mid-operation (EXEC/LOAD/WAIT/DONE) aborts without producing a result; pending result discarded.

Configuration
- REQ-021 SHALL: macro ALU_CTRL_ACC_EN defined: accumulator register updated with res_data at each capture; on acceptance with cmd_use_acc=1, alu_a loads accumulator instead of cmd_a.
- REQ-022 SHALL: ALU_CTRL_ACC_EN undefined: no accumulator register, cmd_use_acc ignored, alu_a always loads cmd_a.

Verification
- REQ-023 SHALL: Rst 2 cycles, then idle -> cmd_ready=1, res_valid=0, alu_rst=0, all data outputs 0.
- REQ-024 SHALL: op 0000, A=0xF0F0F0F0, B=0xFF00FF00, res_ready=1 -> res_valid 2 edges after accept, res_data=0xF000F000, res_err=0, back to IDLE next edge.
- REQ-025 SHALL: op 1000, A=5, B=7 -> alu_rst=1 exactly 1 cycle, busy for SER_WAIT+2 cycles, res_data = alu_f at capture edge (model-checked).
- REQ-026 SHALL: op 1101 -> res_err=1, res_data=0, res_flags=0 after 2 edges.
- REQ-027 SHALL: result held with res_ready=0 for 10 cycles while cmd_valid=1 -> outputs stable, cmd_ready=0, no new acceptance; res_ready=1 -> IDLE.
- REQ-028 SHALL: Rst asserted during WAIT -> IDLE next edge, res_valid never rises; with ALU_CTRL_ACC_EN, op 0100 A=3 B=4 then op 0100 use_acc B=1 -> res_data 7 then 8.

Source files
------------

// File: rtl/alu_ctrl.sv
// Sequencer that issues commands to a downstream ALU, waits for the ALU result and returns it over a valid/ready handshake.
// The optional operand accumulator is enabled by defining ALU_CTRL_ACC_EN.
module alu_ctrl #(
  parameter int SIZE     = 31,
  parameter int SER_WAIT = 33
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [SIZE:0] cmd_a,
  input  logic [SIZE:0] cmd_b,
  input  logic          cmd_use_acc,
  output logic [3:0]    alu_op,
  output logic [SIZE:0] alu_a,
  output logic [SIZE:0] alu_b,
  output logic          alu_rst,
  input  logic [SIZE:0] alu_f,
  input  logic [4:0]    alu_flags,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [SIZE:0] res_data,
  output logic [4:0]    res_flags,
  output logic          res_err,
  output logic          busy
);

  localparam int CW = $clog2(SER_WAIT + 1);

  typedef enum logic [2:0] {IDLE, EXEC, LOAD, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    op_q, op_d;
  logic [SIZE:0] a_q, a_d;
  logic [SIZE:0] b_q, b_d;
  logic [SIZE:0] data_q, data_d;
  logic [4:0]    flags_q, flags_d;
  logic          err_q, err_d;

  logic          capture;
  logic          undefOp;
  logic [SIZE:0] operandA;
  logic [SIZE:0] capData;

  // The serial add is the only op that goes through LOAD/WAIT; everything above it is undefined.
  assign undefOp = (op_q > 4'b1000);
  assign capture = (state_q == EXEC) || ((state_q == WAIT) && (count_q == CW'(1)));
  assign capData = undefOp ? '0 : alu_f;

`ifdef ALU_CTRL_ACC_EN
  logic [SIZE:0] acc_q;

  assign operandA = cmd_use_acc ? acc_q : cmd_a;

  always_ff @(posedge clk) begin
    if (Rst) begin
      acc_q <= '0;
    end else if (capture) begin
      acc_q <= capData;
    end
  end
`else
  logic unusedUseAcc;

  assign operandA     = cmd_a;
  assign unusedUseAcc = cmd_use_acc;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = operandA;
          b_d     = cmd_b;
          state_d = (cmd_op == 4'b1000) ? LOAD : EXEC;
        end
      end
      EXEC: state_d = DONE;
      LOAD: begin
        count_d = CW'(SER_WAIT);
        state_d = WAIT;
      end
      WAIT: begin
        if (count_q == CW'(1)) begin
          count_d = '0;
          state_d = DONE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      data_d  = capData;
      flags_d = undefOp ? 5'b0 : alu_flags;
      err_d   = undefOp;
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // The ALU is held in reset for the whole LOAD cycle so the serial add starts from a clean state.
  assign alu_rst   = Rst | (state_q == LOAD);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign res_data  = data_q;
  assign res_flags = flags_q;
  assign res_err   = err_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Testbench for alu_ctrl: a small ALU model drives alu_f/alu_flags, and a scoreboard checks every result the controller returns.
// The serial-add ALU only produces its sum after the expected number of cycles out of reset, so capture timing is exercised.
module tb_alu_ctrl;

  localparam int SIZE     = 31;
  localparam int SER_WAIT = 33;
  localparam int W        = SIZE + 1;

  logic         clk = 1'b0;
  logic         Rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_use_acc;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_rst;
  logic [W-1:0] alu_f;
  logic [4:0]   alu_flags;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [4:0]   res_flags;
  logic         res_err;
  logic         busy;

  always #5 clk = ~clk;

  alu_ctrl #(.SIZE(SIZE), .SER_WAIT(SER_WAIT)) dut (
    .clk(clk), .Rst(Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_rst(alu_rst),
    .alu_f(alu_f), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_err(res_err), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   flags;
    logic         err;
    int           lat;
    int           acceptCycle;
  } exp_t;

  exp_t         sbQ[$];
  int           checks = 0;
  int           errors = 0;
  int           cycle = 0;
  logic [W-1:0] accModel;
  logic [7:0]   serCnt;

  always @(posedge clk) cycle <= cycle + 1;

  // Flags are {ZF,CF,OF,SF,PF}; undefined ops return junk that the controller must suppress.
  function automatic logic [W+4:0] aluCalc(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   wide;
    logic [W-1:0] f;
    logic         c;
    logic         o;
    c = 1'b0;
    o = 1'b0;
    f = '0;
    wide = '0;
    case (op)
      4'd0: f = a & b;
      4'd1: f = a | b;
      4'd2: f = a ^ b;
      4'd3: f = ~(a & b);
      4'd4, 4'd8: begin
        wide = {1'b0, a} + {1'b0, b};
        f = wide[W-1:0];
        c = wide[W];
        o = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
      end
      4'd5: begin
        wide = {1'b0, a} - {1'b0, b};
        f = wide[W-1:0];
        c = wide[W];
        o = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
      end
      4'd6: f = a << b[4:0];
      4'd7: f = a >> b[4:0];
      default: return {5'b11111, a ^ b};
    endcase
    return {(f == '0), c, o, f[W-1], ~^f[7:0], f};
  endfunction

  // The serial adder counts cycles since its reset and only shows the sum once SER_WAIT cycles of WAIT have elapsed.
  always @(posedge clk) begin
    if (alu_rst) serCnt <= 8'd0;
    else if (serCnt != 8'hFF) serCnt <= serCnt + 8'd1;
  end

  always_comb begin
    if (alu_op == 4'b1000 && serCnt != 8'(SER_WAIT - 1))
      {alu_flags, alu_f} = {5'b0, 32'hDEAD0000 | {24'b0, serCnt}};
    else
      {alu_flags, alu_f} = aluCalc(alu_op, alu_a, alu_b);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor pops the scoreboard when a result appears and then watches it stay put until it is taken.
  exp_t cur;
  logic seen = 1'b0;

  always @(negedge clk) begin
    if (res_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (sbQ.size() == 0) begin
          failTimeout("unexpected result");
          cur.data = res_data;
          cur.flags = res_flags;
          cur.err = res_err;
        end else begin
          cur = sbQ.pop_front();
          checkOutput("res_data", res_data, cur.data);
          checkOutput("res_flags", res_flags, cur.flags);
          checkOutput("res_err", res_err, cur.err);
          checkOutput("latency", cycle - cur.acceptCycle, cur.lat);
        end
      end else begin
        checkOutput("hold res_data", res_data, cur.data);
        checkOutput("hold res_flags", res_flags, cur.flags);
        checkOutput("hold res_err", res_err, cur.err);
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic useAcc);
    exp_t         e;
    logic [W-1:0] effA;
    logic [W+4:0] r;
    int           guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      failTimeout("cmd_ready wait");
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_use_acc = useAcc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    effA = a;
`ifdef ALU_CTRL_ACC_EN
    if (useAcc) effA = accModel;
`endif
    if (op > 4'b1000) begin
      e.data = '0;
      e.flags = '0;
      e.err = 1'b1;
    end else begin
      r = aluCalc(op, effA, b);
      e.data = r[W-1:0];
      e.flags = r[W+4:W];
      e.err = 1'b0;
    end
    accModel = e.data;
    e.lat = (op == 4'b1000) ? SER_WAIT + 1 : 1;
    e.acceptCycle = cycle;
    sbQ.push_back(e);
    checkOutput("alu_op latched", alu_op, op);
    checkOutput("alu_a latched", alu_a, effA);
    checkOutput("alu_b latched", alu_b, b);
  endtask

  task automatic waitIdle(input logic randReady);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 500) begin
      if (randReady) res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) failTimeout("idle wait");
  endtask

  initial begin
    int   guard;
    int   busyCnt;
    int   rstCnt;
    logic rose;
    logic [W-1:0] holdA;

    Rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_use_acc = 1'b0;
    res_ready = 1'b0;
    accModel = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("alu_rst in reset", alu_rst, 1'b1);
    @(negedge clk);
    Rst = 1'b0;
    #1;
    checkOutput("reset cmd_ready", cmd_ready, 1'b1);
    checkOutput("reset res_valid", res_valid, 1'b0);
    checkOutput("reset alu_rst", alu_rst, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset alu_op", alu_op, 4'b0);
    checkOutput("reset alu_a", alu_a, '0);
    checkOutput("reset alu_b", alu_b, '0);
    checkOutput("reset res_data", res_data, '0);
    checkOutput("reset res_flags", res_flags, 5'b0);
    checkOutput("reset res_err", res_err, 1'b0);

    // Single-cycle AND with the result taken immediately.
    res_ready = 1'b1;
    applyStimulus(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
    checkOutput("exec busy", busy, 1'b1);
    checkOutput("exec cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    checkOutput("exec res_valid early", res_valid, 1'b0);
    @(negedge clk);
    checkOutput("and res_valid", res_valid, 1'b1);
    checkOutput("and res_data", res_data, 32'hF000F000);
    @(negedge clk);
    checkOutput("and back idle", cmd_ready, 1'b1);
    checkOutput("and valid fell", res_valid, 1'b0);

    // Serial add: one ALU reset cycle and SER_WAIT+2 busy cycles.
    applyStimulus(4'b1000, 32'd5, 32'd7, 1'b0);
    busyCnt = 0;
    rstCnt = 0;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      busyCnt++;
      if (alu_rst) rstCnt++;
      @(negedge clk);
      guard++;
    end
    checkOutput("serial alu_rst cycles", rstCnt, 1);
    checkOutput("serial busy cycles", busyCnt, SER_WAIT + 2);

    // Undefined op returns an error with zeroed data.
    applyStimulus(4'b1101, $urandom, $urandom, 1'b0);
    waitIdle(1'b0);

    // Result held while a new command is offered and refused.
    res_ready = 1'b0;
    holdA = $urandom;
    applyStimulus(4'b0010, holdA, $urandom, 1'b0);
    guard = 0;
    while (!res_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!res_valid) failTimeout("hold result wait");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = 4'b0000;
      cmd_a = ~holdA;
      #1;
      checkOutput("hold cmd_ready", cmd_ready, 1'b0);
      checkOutput("hold res_valid", res_valid, 1'b1);
      checkOutput("hold alu_a", alu_a, holdA);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold release idle", cmd_ready, 1'b1);
    checkOutput("hold release valid", res_valid, 1'b0);
    checkOutput("hold no accept", alu_a, holdA);

    // Reset in the middle of WAIT discards the pending result.
    applyStimulus(4'b1000, $urandom, $urandom, 1'b0);
    repeat (5) @(negedge clk);
    Rst = 1'b1;
    @(negedge clk);
    Rst = 1'b0;
    sbQ.delete();
    accModel = '0;
    #1;
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort cmd_ready", cmd_ready, 1'b1);
    rose = 1'b0;
    repeat (SER_WAIT + 5) begin
      @(negedge clk);
      if (res_valid) rose = 1'b1;
    end
    checkOutput("abort no result", rose, 1'b0);

`ifdef ALU_CTRL_ACC_EN
    applyStimulus(4'b0100, 32'd3, 32'd4, 1'b0);
    waitIdle(1'b0);
    applyStimulus(4'b0100, $urandom, 32'd1, 1'b1);
    waitIdle(1'b0);
    checkOutput("acc chain result", accModel, 32'd8);
`endif

    // Randomized commands with random result back-pressure.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      waitIdle(1'b1);
    end
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
